data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128: number of 32-bit data words.
REQ-002 SHALL have parameter AW, default 7: address width, with DEPTH = 2**AW.
REQ-003 SHALL have parameter DW, default 32: data word width.
REQ-004 SHALL use one clock and a synchronous, active-low reset; ports listed below are name, direction, width, meaning.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 CEN  in  1  chip enable from the core, active-low.
REQ-008 WEN  in  1  write enable from the core, active-low.
REQ-009 OEN  in  1  output enable from the core, active-low.
REQ-010 A  in  AW  word address from the core.
REQ-011 Data2Mem  in  DW  write data from the core.
REQ-012 ReadDataMem  out  DW  read data returned to the core.
REQ-013 busy  out  1  high while the memory clear sweep runs.
REQ-014 ld_valid / ld_ready  in / out  1 / 1  backdoor preload handshake.
REQ-015 ld_addr / ld_data  in  AW / DW  backdoor preload address and data.
REQ-016 rd_cnt / wr_cnt  out  16 / 16  counts of accepted core reads and writes.

Function
REQ-017 SHALL implement FSM states CLEAR and READY; CLEAR -> READY after the word at address DEPTH-1 is zeroed; READY has no exit except reset.
REQ-018 In CLEAR, SHALL write 0 to address sweep_ptr each cycle, with sweep_ptr running 0..DEPTH-1 (DEPTH cycles total); busy=1 throughout CLEAR.
REQ-019 In CLEAR, SHALL ignore core accesses and loads: no writes, ReadDataMem=0, ld_ready=0, counters frozen.
REQ-020 Core read: in READY with CEN=0, OEN=0 and WEN=1, ReadDataMem SHALL equal mem[A] combinationally, in the same cycle, with zero latency.
REQ-021 In all other cases ReadDataMem SHALL be 0.
REQ-022 Core write: in READY with CEN=0 and WEN=0, mem[A] SHALL take the value of Data2Mem at the rising edge; the new value is visible to a read on the next cycle.
REQ-023 With CEN=0, WEN=0 and OEN=0 together, SHALL perform the write only; ReadDataMem=0 and rd_cnt is not incremented.
REQ-024 With CEN=1, SHALL ignore WEN and OEN entirely.
REQ-025 Backdoor load: ld_ready = (state==READY) AND NOT (CEN=0 AND WEN=0).
REQ-026 On ld_valid AND ld_ready, mem[ld_addr] SHALL take ld_data at the edge.
REQ-027 A core write SHALL always take priority over a backdoor load; a stalled load holds until accepted.
REQ-028 rd_cnt SHALL increment on each cycle with an accepted core read; wr_cnt SHALL increment on each accepted core write.
REQ-029 Both counters SHALL saturate at 0xFFFF; backdoor loads SHALL not be counted.
REQ-030 Address width is exact: A and ld_addr SHALL index directly, with no wrap logic or out-of-range condition.

Reset
REQ-031 On rst_n=0 at an edge: state=CLEAR, sweep_ptr=0, rd_cnt=0, wr_cnt=0, busy=1, ld_ready=0.
REQ-032 While in CLEAR, ReadDataMem SHALL be 0 (per REQ-019).
REQ-033 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from address 0; array contents are not otherwise guaranteed until the sweep completes.

Structure
REQ-034 Package mem_pkg SHALL hold: state enum {CLEAR, READY}, DEPTH/AW/DW defaults, and the counter width 16.
REQ-035 Storage SHALL be one sub-module sram_array_128x32: one write port, one asynchronous read port.
REQ-036 The write-port mux (sweep / core / load) and the FSM SHALL live in data_mem_responder.

Verification
REQ-037 Reset released -> busy=1 for exactly 128 cycles, then 0; a read of any address then returns 0x00000000.
REQ-038 Write 0xDEADBEEF to A=5, then read A=5 next cycle -> ReadDataMem=0xDEADBEEF, wr_cnt=1, rd_cnt=1.
REQ-039 Core write to A=3 and ld_valid to ld_addr=3 with 0x11111111 in the same cycle -> ld_ready=0, mem[3]=core data; load lands next cycle.
REQ-040 CEN=0, WEN=0, OEN=0 to A=9 with 0xA5A5A5A5 -> ReadDataMem=0 that cycle, rd_cnt unchanged; later read of A=9 returns 0xA5A5A5A5.
REQ-041 rst_n pulsed at sweep_ptr=60 -> sweep restarts at 0, busy high for a further 128 cycles.
REQ-042 70000 back-to-back reads -> rd_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/mem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the data memory responder: default
//               geometry, counter width, FSM state encoding and a saturating
//               counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_depth = 128;  // data words
    localparam int c_aw    = 7;    // word address width, c_depth == 2**c_aw
    localparam int c_dw    = 32;   // data word width
    localparam int c_cnt_w = 16;   // access counter width

    // Explicit 1-bit encoding: CLEAR is the reset state.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] value);
        if (value == {c_cnt_w{1'b1}}) begin
            return value;
        end
        return value + c_cnt_w'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array_128x32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sram_array_128x32
// Description : Word storage with one synchronous write port and one
//               asynchronous (combinational) read port. No reset: contents
//               are initialised by the owner's clear sweep.
// Ports       : clk      - write clock
//               i_we     - write enable
//               i_waddr  - write word address
//               i_wdata  - write data
//               i_raddr  - read word address
//               o_rdata  - read data, combinational from i_raddr
// Revision    : 1.0 - initial release
// ============================================================================
module sram_array_128x32
    import mem_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int AW    = c_aw,
    parameter int DW    = c_dw
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Zero-latency read: the core expects data in the same cycle it asks.
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data memory seen by the core through an SRAM-style,
//               active-low CEN/WEN/OEN interface, with a backdoor preload
//               port and saturating read/write access counters. After reset
//               the whole array is swept to zero (busy high) before any
//               access is honoured.
// Ports       : clk, rst_n         - clock, synchronous active-low reset
//               CEN, WEN, OEN      - core chip/write/output enables (low)
//               A, Data2Mem        - core word address and write data
//               ReadDataMem        - core read data (0 unless reading)
//               busy               - clear sweep in progress
//               ld_valid/ld_ready  - backdoor preload handshake
//               ld_addr, ld_data   - backdoor preload address and data
//               rd_cnt, wr_cnt     - accepted core reads / writes, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int AW    = c_aw,
    parameter int DW    = c_dw
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               CEN,
    input  logic               WEN,
    input  logic               OEN,
    input  logic [AW-1:0]      A,
    input  logic [DW-1:0]      Data2Mem,
    output logic [DW-1:0]      ReadDataMem,
    output logic               busy,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [AW-1:0]      ld_addr,
    input  logic [DW-1:0]      ld_data,
    output logic [c_cnt_w-1:0] rd_cnt,
    output logic [c_cnt_w-1:0] wr_cnt
);

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [AW-1:0]        r_sweep_ptr;
    logic [c_cnt_w-1:0]   r_rd_cnt;
    logic [c_cnt_w-1:0]   r_wr_cnt;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic                 w_ready;
    logic                 w_core_sel;
    logic                 w_core_wr;
    logic                 w_core_rd;
    logic                 w_ld_ready;
    logic                 w_ld_acc;

    assign w_ready    = (r_state == READY);
    // CEN high masks WEN/OEN completely.
    assign w_core_sel = w_ready && !CEN;
    assign w_core_wr  = w_core_sel && !WEN;
    // A write with OEN also low is a write only, so WEN must be high here.
    assign w_core_rd  = w_core_sel && WEN && !OEN;
    // The single write port belongs to the core whenever it writes; the
    // preload port is stalled (not dropped) for that cycle.
    assign w_ld_ready = w_ready && !w_core_wr;
    assign w_ld_acc   = ld_valid && w_ld_ready;

    // ------------------------------------------------------------------
    // Write-port mux: sweep > core write > backdoor load
    // ------------------------------------------------------------------
    logic                 w_we;
    logic [AW-1:0]        w_waddr;
    logic [DW-1:0]        w_wdata;
    logic [DW-1:0]        w_rdata;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_sweep_ptr;
        w_wdata = '0;
        if (!w_ready) begin
            w_we    = 1'b1;
        end else if (w_core_wr) begin
            w_we    = 1'b1;
            w_waddr = A;
            w_wdata = Data2Mem;
        end else if (w_ld_acc) begin
            w_we    = 1'b1;
            w_waddr = ld_addr;
            w_wdata = ld_data;
        end
    end

    sram_array_128x32 #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (A),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // FSM, sweep pointer and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= CLEAR;
            r_sweep_ptr <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    // The last word is zeroed on the same edge that leaves
                    // CLEAR, giving exactly DEPTH busy cycles.
                    if (r_sweep_ptr == c_last_addr) begin
                        r_state <= READY;
                    end
                    r_sweep_ptr <= r_sweep_ptr + AW'(1);
                end
                READY: begin
                    r_state <= READY;
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase

            if (w_core_rd) begin
                r_rd_cnt <= sat_inc(r_rd_cnt);
            end
            if (w_core_wr) begin
                r_wr_cnt <= sat_inc(r_wr_cnt);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ReadDataMem = w_core_rd ? w_rdata : '0;
    assign busy        = (r_state == CLEAR);
    assign ld_ready    = w_ld_ready;
    assign rd_cnt      = r_rd_cnt;
    assign wr_cnt      = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed-vector bench for data_mem_responder. The stimulus
//               process queues the expected output values for each cycle it
//               drives; a monitor process pops and compares them on the
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int c_f_rdata = 0;
    localparam int c_f_busy  = 1;
    localparam int c_f_ldrdy = 2;
    localparam int c_f_rdcnt = 3;
    localparam int c_f_wrcnt = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                CEN;
    logic                WEN;
    logic                OEN;
    logic [c_aw-1:0]     A;
    logic [c_dw-1:0]     Data2Mem;
    logic [c_dw-1:0]     ReadDataMem;
    logic                busy;
    logic                ld_valid;
    logic                ld_ready;
    logic [c_aw-1:0]     ld_addr;
    logic [c_dw-1:0]     ld_data;
    logic [c_cnt_w-1:0]  rd_cnt;
    logic [c_cnt_w-1:0]  wr_cnt;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem),
        .busy        (busy),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    string       q_name [$];
    int          q_field[$];
    logic [31:0] q_exp  [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic expect_val(input string name, input int field, input logic [31:0] exp);
        q_name.push_back(name);
        q_field.push_back(field);
        q_exp.push_back(exp);
    endtask

    function automatic logic [31:0] sample(input int field);
        case (field)
            c_f_rdata: sample = ReadDataMem;
            c_f_busy:  sample = {31'd0, busy};
            c_f_ldrdy: sample = {31'd0, ld_ready};
            c_f_rdcnt: sample = {16'd0, rd_cnt};
            c_f_wrcnt: sample = {16'd0, wr_cnt};
            default:   sample = 32'hxxxx_xxxx;
        endcase
    endfunction

    initial begin : monitor
        string       nm;
        int          fld;
        logic [31:0] exp_v;
        logic [31:0] act_v;
        forever begin
            @(negedge clk);
            while (q_exp.size() > 0) begin
                nm    = q_name.pop_front();
                fld   = q_field.pop_front();
                exp_v = q_exp.pop_front();
                act_v = sample(fld);
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act_v, exp_v);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cen, input logic wen, input logic oen,
                         input logic [c_aw-1:0] a, input logic [c_dw-1:0] d,
                         input logic ldv, input logic [c_aw-1:0] lda,
                         input logic [c_dw-1:0] ldd);
        CEN      = cen;
        WEN      = wen;
        OEN      = oen;
        A        = a;
        Data2Mem = d;
        ld_valid = ldv;
        ld_addr  = lda;
        ld_data  = ldd;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, '0, '0);
    endtask

    // One core read of addr, checking the data returned this cycle.
    task automatic core_read(input string name, input logic [c_aw-1:0] addr,
                             input logic [c_dw-1:0] exp_data);
        drive(1'b0, 1'b1, 1'b0, addr, '0, 1'b0, '0, '0);
        expect_val(name, c_f_rdata, exp_data);
        tick();
    endtask

    // Holds CLEAR-phase expectations for n cycles; with poke set, also tries
    // a read, a write and a load that must all be ignored.
    task automatic run_clear(input int n, input bit poke);
        for (int i = 0; i < n; i++) begin
            idle();
            if (poke && i == 10) drive(1'b0, 1'b1, 1'b0, 7'd0, '0, 1'b0, '0, '0);
            if (poke && i == 50) drive(1'b0, 1'b0, 1'b1, 7'd7, 32'h1234_5678, 1'b0, '0, '0);
            if (poke && i == 60) drive(1'b1, 1'b1, 1'b1, '0, '0, 1'b1, 7'd8, 32'h8765_4321);
            expect_val("clear_busy", c_f_busy, 32'd1);
            expect_val("clear_rdata", c_f_rdata, 32'd0);
            expect_val("clear_ld_ready", c_f_ldrdy, 32'd0);
            if (i == n - 1) begin
                expect_val("clear_rd_cnt", c_f_rdcnt, 32'd0);
                expect_val("clear_wr_cnt", c_f_wrcnt, 32'd0);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stim
        logic [c_aw-1:0] zero_addrs[4];
        zero_addrs = '{7'd0, 7'd7, 7'd8, 7'd127};

        rst_n = 1'b0;
        idle();
        tick();
        tick();

        expect_val("reset_busy", c_f_busy, 32'd1);
        expect_val("reset_ld_ready", c_f_ldrdy, 32'd0);
        expect_val("reset_rd_cnt", c_f_rdcnt, 32'd0);
        expect_val("reset_wr_cnt", c_f_wrcnt, 32'd0);
        expect_val("reset_rdata", c_f_rdata, 32'd0);
        tick();

        rst_n = 1'b1;
        run_clear(128, 1'b1);

        // Write then read back.
        drive(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
        expect_val("ready_busy", c_f_busy, 32'd0);
        expect_val("wr_ld_ready", c_f_ldrdy, 32'd0);
        expect_val("wr_rdata", c_f_rdata, 32'd0);
        expect_val("wr_cnt_before", c_f_wrcnt, 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 7'd5, '0, 1'b0, '0, '0);
        expect_val("rd5_data", c_f_rdata, 32'hDEAD_BEEF);
        expect_val("rd5_wr_cnt", c_f_wrcnt, 32'd1);
        expect_val("rd5_ld_ready", c_f_ldrdy, 32'd1);
        tick();
        idle();
        expect_val("after_rd5_rd_cnt", c_f_rdcnt, 32'd1);
        expect_val("after_rd5_wr_cnt", c_f_wrcnt, 32'd1);
        expect_val("idle_rdata", c_f_rdata, 32'd0);
        tick();

        // Swept words, including the ones poked during CLEAR, read as zero.
        foreach (zero_addrs[k]) core_read("swept_zero", zero_addrs[k], 32'd0);

        // Core write and load to the same word in one cycle.
        drive(1'b0, 1'b0, 1'b1, 7'd3, 32'hCAFE_F00D, 1'b1, 7'd3, 32'h1111_1111);
        expect_val("collide_ld_ready", c_f_ldrdy, 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 7'd3, '0, 1'b1, 7'd3, 32'h1111_1111);
        expect_val("collide_core_data", c_f_rdata, 32'hCAFE_F00D);
        expect_val("stalled_ld_ready", c_f_ldrdy, 32'd1);
        expect_val("collide_wr_cnt", c_f_wrcnt, 32'd2);
        tick();
        core_read("load_landed", 7'd3, 32'h1111_1111);

        // Write with OEN also low: no read data, no read count.
        drive(1'b0, 1'b0, 1'b0, 7'd9, 32'hA5A5_A5A5, 1'b0, '0, '0);
        expect_val("wr_oen_rdata", c_f_rdata, 32'd0);
        expect_val("wr_oen_rd_cnt", c_f_rdcnt, 32'd7);
        tick();
        drive(1'b0, 1'b1, 1'b0, 7'd9, '0, 1'b0, '0, '0);
        expect_val("rd9_data", c_f_rdata, 32'hA5A5_A5A5);
        expect_val("rd9_rd_cnt", c_f_rdcnt, 32'd7);
        expect_val("rd9_wr_cnt", c_f_wrcnt, 32'd3);
        tick();

        // CEN high masks WEN and OEN.
        drive(1'b1, 1'b0, 1'b0, 7'd9, 32'h0000_0000, 1'b0, '0, '0);
        expect_val("cen_hi_rdata", c_f_rdata, 32'd0);
        expect_val("cen_hi_ld_ready", c_f_ldrdy, 32'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 7'd9, '0, 1'b0, '0, '0);
        expect_val("cen_hi_kept", c_f_rdata, 32'hA5A5_A5A5);
        expect_val("cen_hi_wr_cnt", c_f_wrcnt, 32'd3);
        expect_val("cen_hi_rd_cnt", c_f_rdcnt, 32'd8);
        tick();

        // Backdoor loads, one while idle and one alongside a core read.
        drive(1'b1, 1'b1, 1'b1, '0, '0, 1'b1, 7'd127, 32'h0BAD_F00D);
        expect_val("ld_idle_ready", c_f_ldrdy, 32'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 7'd127, '0, 1'b1, 7'd0, 32'h00C0_FFEE);
        expect_val("ld127_data", c_f_rdata, 32'h0BAD_F00D);
        expect_val("ld_rd_ready", c_f_ldrdy, 32'd1);
        tick();
        core_read("ld0_data", 7'd0, 32'h00C0_FFEE);
        idle();
        expect_val("ld_not_counted_wr", c_f_wrcnt, 32'd3);
        expect_val("ld_rd_cnt", c_f_rdcnt, 32'd11);
        tick();

        // Reset, then abort the sweep at pointer 60 with a second reset.
        rst_n = 1'b0;
        tick();
        expect_val("rst2_busy", c_f_busy, 32'd1);
        expect_val("rst2_rd_cnt", c_f_rdcnt, 32'd0);
        expect_val("rst2_wr_cnt", c_f_wrcnt, 32'd0);
        rst_n = 1'b1;
        run_clear(60, 1'b0);
        rst_n = 1'b0;
        expect_val("abort_busy", c_f_busy, 32'd1);
        tick();
        rst_n = 1'b1;
        run_clear(128, 1'b0);
        idle();
        expect_val("resweep_busy_low", c_f_busy, 32'd0);
        tick();
        core_read("resweep_a5", 7'd5, 32'd0);
        core_read("resweep_a3", 7'd3, 32'd0);
        core_read("resweep_a127", 7'd127, 32'd0);

        // Back-to-back reads drive rd_cnt into saturation (starts at 3).
        for (int i = 0; i < 70000; i++) begin
            drive(1'b0, 1'b1, 1'b0, c_aw'(i), '0, 1'b0, '0, '0);
            if (i == 0)     expect_val("sat_start", c_f_rdcnt, 32'd3);
            if (i == 65531) expect_val("sat_fffe", c_f_rdcnt, 32'h0000_FFFE);
            if (i == 65532) expect_val("sat_ffff", c_f_rdcnt, 32'h0000_FFFF);
            if (i == 69999) expect_val("sat_hold", c_f_rdcnt, 32'h0000_FFFF);
            tick();
        end
        idle();
        expect_val("sat_final", c_f_rdcnt, 32'h0000_FFFF);
        expect_val("sat_wr_cnt", c_f_wrcnt, 32'd0);
        tick();

        @(negedge clk);
        #1;
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
